// File: rtl/cdc_read_bridge.sv
// cdc_read_bridge: carries a read address from src_clk to dst_clk and the read data back over one 4-phase req/ack handshake
module cdc_read_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  src_clk,
    input  logic                  src_rst_n,
    input  logic                  src_req_valid,
    input  logic [ADDR_WIDTH-1:0] src_req_addr,
    output logic                  src_req_ready,
    output logic                  src_rsp_valid,
    output logic [DATA_WIDTH-1:0] src_rsp_data,
    output logic                  src_rsp_err,
    input  logic                  src_rsp_ready,
    input  logic                  dst_clk,
    input  logic                  dst_rst_n,
    output logic                  dst_rd_en,
    output logic [ADDR_WIDTH-1:0] dst_rd_addr,
    input  logic                  dst_rd_valid,
    input  logic [DATA_WIDTH-1:0] dst_rd_data
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} src_state_t;
    typedef enum logic [1:0] {D_IDLE, D_READ, D_ACK} dst_state_t;

    src_state_t src_state, src_next;
    dst_state_t dst_state, dst_next;

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [NUM_STAGES-1:0] ack_pipe;
    logic                  ack_sync;
    logic                  src_fire;

    logic                  ack;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  err_reg;
    logic [NUM_STAGES-1:0] req_pipe;
    logic                  req_sync;
    logic [CW-1:0]         cnt;
    logic                  timeout;

    assign ack_sync      = ack_pipe[NUM_STAGES-1];
    assign req_sync      = req_pipe[NUM_STAGES-1];
    assign src_req_ready = (src_state == S_IDLE) && !ack_sync && !src_rsp_valid;
    assign src_fire      = src_req_valid && src_req_ready;
    assign timeout       = (TIMEOUT_CYCLES > 0) && (cnt == CNT_MAX);

    // ack synchronizer resets high so a freshly reset src side waits for a real low ack before accepting
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) ack_pipe <= '1;
        else            ack_pipe <= {ack_pipe[NUM_STAGES-2:0], ack};
    end

    // src state register
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) src_state <= S_IDLE;
        else            src_state <= src_next;
    end

    // src next state: request, wait for ack, wait for ack release
    always_comb begin
        src_next = src_state;
        case (src_state)
            S_IDLE:  if (src_fire) src_next = S_REQ;
            S_REQ:   if (ack_sync) src_next = S_DROP;
            S_DROP:  if (!ack_sync) src_next = S_IDLE;
            default: src_next = S_IDLE;
        endcase
    end

    // src datapath: address latch, req level, response capture and hand-off
    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            req           <= 1'b0;
            addr_reg      <= '0;
            src_rsp_valid <= 1'b0;
            src_rsp_data  <= '0;
            src_rsp_err   <= 1'b0;
        end else begin
            if (src_fire) begin
                addr_reg <= src_req_addr;
                req      <= 1'b1;
            end
            if (src_state == S_REQ && ack_sync) begin
                req           <= 1'b0;
                src_rsp_valid <= 1'b1;
                src_rsp_data  <= data_reg;
                src_rsp_err   <= err_reg;
            end else if (src_rsp_valid && src_rsp_ready) begin
                src_rsp_valid <= 1'b0;
            end
        end
    end

    // req synchronizer into the dst domain
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) req_pipe <= '0;
        else            req_pipe <= {req_pipe[NUM_STAGES-2:0], req};
    end

    // dst state register
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) dst_state <= D_IDLE;
        else            dst_state <= dst_next;
    end

    // dst next state: strobe the read, await data or timeout, hold ack until req drops
    always_comb begin
        dst_next = dst_state;
        case (dst_state)
            D_IDLE:  if (req_sync && !ack) dst_next = D_READ;
            D_READ:  if (dst_rd_valid || timeout) dst_next = D_ACK;
            D_ACK:   if (!req_sync) dst_next = D_IDLE;
            default: dst_next = D_IDLE;
        endcase
    end

    // dst datapath: address is only sampled once req_sync is high, so addr_reg is already stable
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            dst_rd_en   <= 1'b0;
            dst_rd_addr <= '0;
            ack         <= 1'b0;
            data_reg    <= '0;
            err_reg     <= 1'b0;
            cnt         <= '0;
        end else begin
            dst_rd_en <= 1'b0;
            case (dst_state)
                D_IDLE: if (req_sync && !ack) begin
                    dst_rd_addr <= addr_reg;
                    dst_rd_en   <= 1'b1;
                    cnt         <= '0;
                end
                D_READ: if (dst_rd_valid) begin
                    data_reg <= dst_rd_data;
                    err_reg  <= 1'b0;
                    ack      <= 1'b1;
                end else if (timeout) begin
                    data_reg <= '0;
                    err_reg  <= 1'b1;
                    ack      <= 1'b1;
                end else begin
                    cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end
                D_ACK: if (!req_sync) ack <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_read_bridge.sv
// tb_cdc_read_bridge: directed checks of the cross-clock read bridge against a reference memory
module tb_cdc_read_bridge;

    logic        src_clk = 1'b0;
    logic        dst_clk = 1'b0;
    int          src_half = 5;
    int          dst_half = 5;
    logic        src_rst_n, dst_rst_n;
    logic        src_req_valid, src_req_ready, src_rsp_valid, src_rsp_err, src_rsp_ready;
    logic [7:0]  src_req_addr, dst_rd_addr;
    logic [31:0] src_rsp_data, dst_rd_data;
    logic        dst_rd_en, dst_rd_valid;

    logic [31:0] mem [256];
    int          vectors = 0;
    int          miscompares = 0;
    int          rd_cnt = 0;
    int          exp_rd = 0;
    int          mode = 0;
    int          lat, n;
    logic        rdy, stable, stale;
    logic [7:0]  last_addr, a;
    logic [31:0] snap;

    cdc_read_bridge dut (
        .src_clk(src_clk), .src_rst_n(src_rst_n),
        .src_req_valid(src_req_valid), .src_req_addr(src_req_addr), .src_req_ready(src_req_ready),
        .src_rsp_valid(src_rsp_valid), .src_rsp_data(src_rsp_data), .src_rsp_err(src_rsp_err),
        .src_rsp_ready(src_rsp_ready),
        .dst_clk(dst_clk), .dst_rst_n(dst_rst_n),
        .dst_rd_en(dst_rd_en), .dst_rd_addr(dst_rd_addr),
        .dst_rd_valid(dst_rd_valid), .dst_rd_data(dst_rd_data)
    );

    always #(src_half) src_clk = ~src_clk;
    always #(dst_half) dst_clk = ~dst_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] addr);
        int k = 0;
        while (!src_req_ready && k < 500) begin
            @(negedge src_clk);
            k++;
        end
        check("req_ready", {63'd0, src_req_ready}, 64'd1);
        src_req_valid = 1'b1;
        src_req_addr  = addr;
        exp_rd++;
        @(negedge src_clk);
        src_req_valid = 1'b0;
    endtask

    task automatic get_rsp(output int l, output logic r);
        l = 0;
        r = 1'b0;
        while (!src_rsp_valid && l < 3000) begin
            @(negedge src_clk);
            l++;
            if (src_req_ready) r = 1'b1;
        end
    endtask

    task automatic accept();
        src_rsp_ready = 1'b1;
        @(negedge src_clk);
        src_rsp_ready = 1'b0;
    endtask

    task automatic read_txn(input logic [7:0] addr, input string tag);
        int l;
        logic r;
        issue(addr);
        get_rsp(l, r);
        check(tag, {30'd0, src_rsp_valid, src_rsp_err, src_rsp_data}, {30'd0, 1'b1, 1'b0, mem[addr]});
        accept();
    endtask

    // responder: 0 zero-wait, 1 silent, 2 random 0-10 delay, 3 silent then a late pulse during the ack phase
    initial begin
        dst_rd_valid = 1'b0;
        dst_rd_data  = '0;
        forever begin
            @(negedge dst_clk);
            dst_rd_valid = 1'b0;
            if (dst_rd_en) begin
                rd_cnt++;
                last_addr = dst_rd_addr;
                if (mode == 0 || mode == 2) begin
                    if (mode == 2) repeat ($urandom_range(0, 10)) @(negedge dst_clk);
                    dst_rd_valid = 1'b1;
                    dst_rd_data  = mem[last_addr];
                end else if (mode == 3) begin
                    repeat (66) @(negedge dst_clk);
                    dst_rd_valid = 1'b1;
                    dst_rd_data  = 32'h1234_5678;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h3C] = 32'hDEAD_BEEF;
        src_rst_n = 1'b0; dst_rst_n = 1'b0;
        src_req_valid = 1'b0; src_req_addr = '0; src_rsp_ready = 1'b0;
        repeat (3) @(negedge src_clk);
        check("rst_ready_low", {63'd0, src_req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, src_rsp_valid}, 64'd0);
        src_rst_n = 1'b1; dst_rst_n = 1'b1;
        repeat (3) @(negedge src_clk);
        check("post_rst_ready", {63'd0, src_req_ready}, 64'd1);
        check("post_rst_rsp_valid", {63'd0, src_rsp_valid}, 64'd0);
        check("post_rst_rd_en", {63'd0, dst_rd_en}, 64'd0);
        check("post_rst_rsp_data", {32'd0, src_rsp_data}, 64'd0);

        // zero-wait read on equal in-phase clocks
        issue(8'h3C);
        get_rsp(lat, rdy);
        check("t2_latency", 64'(lat), 64'd7);
        check("t2_ready_while_busy", {63'd0, rdy}, 64'd0);
        check("t2_rsp", {30'd0, src_rsp_valid, src_rsp_err, src_rsp_data}, {30'd0, 2'b10, 32'hDEAD_BEEF});
        check("t2_rd_en_count", 64'(rd_cnt), 64'd1);
        check("t2_rd_addr", {56'd0, last_addr}, 64'h3C);
        accept();
        n = 0;
        while (!src_req_ready && n < 100) begin
            @(negedge src_clk);
            n++;
        end
        check("t2_ready_after_ack_drop", 64'(n), 64'd5);

        // timeout, with a late responder pulse landing while the ack is held
        mode = 3;
        issue(8'h10);
        get_rsp(lat, rdy);
        check("t3_latency", 64'(lat), 64'd71);
        check("t3_rsp", {30'd0, src_rsp_valid, src_rsp_err, src_rsp_data}, {30'd0, 2'b11, 32'd0});
        accept();
        mode = 0;
        read_txn(8'h11, "t3_recover");

        // response back-pressure
        issue(8'h55);
        get_rsp(lat, rdy);
        check("t4_rsp", {30'd0, src_rsp_valid, src_rsp_err, src_rsp_data}, {30'd0, 2'b10, mem[8'h55]});
        snap = src_rsp_data;
        src_req_valid = 1'b1;
        src_req_addr  = 8'h66;
        stable = 1'b1;
        repeat (20) begin
            @(negedge src_clk);
            if (!src_rsp_valid || src_rsp_data !== snap || src_req_ready) stable = 1'b0;
        end
        check("t4_hold_stable", {63'd0, stable}, 64'd1);
        src_rsp_ready = 1'b1;
        @(negedge src_clk);
        src_rsp_ready = 1'b0;
        check("t4_valid_ready_after_accept", {62'd0, src_rsp_valid, src_req_ready}, 64'b01);
        exp_rd++;
        @(negedge src_clk);
        src_req_valid = 1'b0;
        check("t4_new_req_taken", {63'd0, src_req_ready}, 64'd0);
        get_rsp(lat, rdy);
        check("t4_rsp2", {30'd0, src_rsp_valid, src_rsp_err, src_rsp_data}, {30'd0, 2'b10, mem[8'h66]});
        accept();

        // dst reset while the read is outstanding: dst re-issues the read
        mode = 1;
        issue(8'h21);
        n = 0;
        while (rd_cnt != exp_rd && n < 50) begin
            @(negedge dst_clk);
            n++;
        end
        dst_rst_n = 1'b0;
        repeat (2) @(negedge dst_clk);
        mode = 0;
        dst_rst_n = 1'b1;
        exp_rd++;
        get_rsp(lat, rdy);
        check("dst_rst_reissue_rsp", {30'd0, src_rsp_valid, src_rsp_err, src_rsp_data}, {30'd0, 2'b10, mem[8'h21]});
        accept();

        // random reads with unequal clocks and random responder delay
        mode = 2;
        src_half = 5; dst_half = 15;
        for (int i = 0; i < 50; i++) begin
            if (i == 25) begin
                src_half = 15;
                dst_half = 5;
            end
            a = 8'($urandom_range(0, 255));
            read_txn(a, "t5_random_read");
        end

        // src reset while waiting for the ack
        mode = 0;
        src_half = 5; dst_half = 5;
        repeat (4) @(negedge src_clk);
        issue(8'h77);
        repeat (5) @(negedge src_clk);
        src_rst_n = 1'b0;
        @(negedge src_clk);
        check("t6_in_reset", {62'd0, src_rsp_valid, src_req_ready}, 64'd0);
        @(negedge src_clk);
        src_rst_n = 1'b1;
        n = 0;
        stale = 1'b0;
        while (!src_req_ready && n < 200) begin
            @(negedge src_clk);
            n++;
            if (src_rsp_valid) stale = 1'b1;
        end
        check("t6_ready_back", {63'd0, src_req_ready}, 64'd1);
        check("t6_ready_waited", {63'd0, n >= 2}, 64'd1);
        check("t6_no_stale_rsp", {63'd0, stale}, 64'd0);
        read_txn(8'h88, "t6_next_read");

        repeat (10) @(negedge src_clk);
        check("rd_en_total", 64'(rd_cnt), 64'(exp_rd));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
